// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the transmitter and receiver:
//               transmit FSM state type, frame constants and the default
//               bit period.
//               Optional feature macro: UART_TX_PARITY_EN (adds PARITY state).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int   UART_DATA_BITS    = 8;
  localparam logic UART_IDLE_LEVEL   = 1'b1;
  // 50 MHz system clock / 115200 baud
  localparam int   UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_if
// Description : Byte-request / status bundle between the message selector
//               (master) and the UART frame transmitter (slave).
//   tx_data  : byte to send, sampled on the accepting edge
//   tx_start : level request, accepted only while the transmitter is idle
//   tx       : serial line, idle high
//   tx_busy  : frame in progress
//   tx_done  : one-cycle pulse after the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_start;
  logic                      tx;
  logic                      tx_busy;
  logic                      tx_done;

  modport master (
    output tx_data,
    output tx_start,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx,
    output tx_busy,
    output tx_done
  );

endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Free-running bit-period counter, 0..CLKS_PER_BIT-1, held at
//               zero while cleared. Emits o_bit_tick on the last cycle of
//               every bit period. Shared by the UART transmitter and receiver.
//   clk_50M    : system clock
//   rst_n      : asynchronous active-low reset
//   i_clear    : hold the counter at zero (no tick while asserted)
//   o_bit_tick : high during the last cycle of each bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  wire logic clk_50M,
  input  wire logic rst_n,
  input  wire logic i_clear,
  output logic      o_bit_tick
);

  localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || (r_count == c_LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_bit_tick = !i_clear && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : Serialises one accepted byte into an asynchronous UART frame,
//               8-N-1 by default or 8-E-1 when UART_TX_PARITY_EN is defined.
//               All outputs are registered.
//   clk_50M     : system clock, rising edge
//   rst_n       : asynchronous active-low reset (line returns idle-high)
//   bus (slave) : tx_data / tx_start in, tx / tx_busy / tx_done out
// Parameter   : CLKS_PER_BIT - clock cycles per UART bit (2..65535)
// Macro       : UART_TX_PARITY_EN - insert even parity bit after data bit 7
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  wire logic      clk_50M,
  input  wire logic      rst_n,
  uart_tx_frame_if.slave bus
);

  localparam int                 c_IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(UART_DATA_BITS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  uart_tx_state_t            r_state, w_state_next;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
  logic [c_IDX_W-1:0]        r_bit_idx, w_bit_idx_next;
  logic                      r_tx, w_tx_next;
  logic                      r_busy, w_busy_next;
  logic                      r_done, w_done_next;
  logic                      w_bit_tick;
  logic                      w_timer_clear;

  // Timer sits at zero while idle, so the first bit period starts cleanly
  // on the cycle after acceptance.
  assign w_timer_clear = (r_state == S_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .i_clear    (w_timer_clear),
    .o_bit_tick (w_bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  // Even parity of the accepted byte, frozen for the whole frame.
  logic r_parity;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.tx_start) begin
      r_parity <= ^bus.tx_data;
    end
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= UART_IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  // Next state, then the line level for that next state so that tx is a
  // pure register output with the level already valid in the new state.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_done_next    = 1'b0;
    w_tx_next      = UART_IDLE_LEVEL;
    w_busy_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.tx_start) begin
          w_state_next   = S_START;
          w_shift_next   = bus.tx_data;
          w_bit_idx_next = '0;
        end
      end
      S_START: begin
        if (w_bit_tick) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_tick) begin
          w_shift_next   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
          w_bit_idx_next = r_bit_idx + c_IDX_ONE;
          if (r_bit_idx == c_LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_tick) begin
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_tick) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    case (w_state_next)
      S_START: begin
        w_tx_next   = ~UART_IDLE_LEVEL;
        w_busy_next = 1'b1;
      end
      S_DATA: begin
        w_tx_next   = w_shift_next[0];
        w_busy_next = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx_next   = r_parity;
        w_busy_next = 1'b1;
      end
`endif
      S_STOP: begin
        w_tx_next   = UART_IDLE_LEVEL;
        w_busy_next = 1'b1;
      end
      default: begin
        w_tx_next   = UART_IDLE_LEVEL;
        w_busy_next = 1'b0;
      end
    endcase
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame with CLKS_PER_BIT=4.
//               A frame-level reference model predicts tx/tx_busy/tx_done
//               every cycle; directed scenarios add literal expectations.
//               Honours UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_50M = ~clk_50M;

  uart_tx_frame_if bus();

  uart_tx_frame #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame as a bit vector) ----------------
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
`ifdef UART_TX_PARITY_EN
    b[9]   = ^d;
`endif
    return b;
  endfunction

  logic        m_active;
  logic        m_done;
  int          m_cnt;
  logic [10:0] m_bits;

  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_cnt    <= 0;
      m_bits   <= '1;
    end else if (m_active) begin
      if (m_cnt == FLEN) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_cnt  <= m_cnt + 1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.tx_start) begin
        m_active <= 1'b1;
        m_cnt    <= 1;
        m_bits   <= frame_bits(bus.tx_data);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_50M) begin
    logic exp_tx;
    exp_tx = m_active ? m_bits[(m_cnt - 1) / CPB] : 1'b1;
    check("model_tx",   int'(bus.tx),      int'(exp_tx));
    check("model_busy", int'(bus.tx_busy), int'(m_active));
    check("model_done", int'(bus.tx_done), int'(m_done));
  end

  // ---------------- per-scenario capture ----------------
  int cap [0:199];
  int busy_cnt, done_cnt, done_at;
  int rise_q[$];

  task automatic clear_stats();
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    rise_q.delete();
  endtask

  // Called at a negedge; advances to the next negedge and records outputs.
  task automatic step_sample(input int i);
    logic pb;
    pb = bus.tx_busy;
    @(negedge clk_50M);
    cap[i] = int'(bus.tx);
    if (bus.tx_busy) busy_cnt++;
    if (bus.tx_done) begin
      done_cnt++;
      done_at = i;
    end
    if (bus.tx_busy && !pb) rise_q.push_back(i);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk_50M);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lit_a5 [0:10];
    int lit_81 [0:10];
    lit_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    lit_81 = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
`ifdef UART_TX_PARITY_EN
    lit_a5[9] = 0;    // 0xA5 has four ones
    lit_81[9] = 0;    // 0x81 has two ones
`endif

    // ---- reset held with tx_start asserted ----
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hA5;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_50M);
      check("rst_tx",   int'(bus.tx),      1);
      check("rst_busy", int'(bus.tx_busy), 0);
      check("rst_done", int'(bus.tx_done), 0);
    end
    bus.tx_start = 1'b0;
    rst_n        = 1'b1;
    idle_cycles(3);

    // ---- single frame 0xA5 ----
    clear_stats();
    bus.tx_data  = 8'hA5;
    bus.tx_start = 1'b1;
    for (int i = 0; i < FLEN + 5; i++) begin
      step_sample(i);
      if (i == 0) bus.tx_start = 1'b0;
    end
    for (int i = 0; i < FLEN; i++) check("a5_bit", cap[i], lit_a5[i / CPB]);
    check("a5_idle_after", cap[FLEN + 2], 1);
    check("a5_busy_len",   busy_cnt, FLEN);
    check("a5_done_cnt",   done_cnt, 1);
    check("a5_done_at",    done_at,  FLEN);
    idle_cycles(3);

    // ---- request while busy is ignored ----
    clear_stats();
    bus.tx_data  = 8'hFF;
    bus.tx_start = 1'b1;
    for (int i = 0; i < FLEN + 12; i++) begin
      step_sample(i);
      if (i == 0)  bus.tx_start = 1'b0;
      if (i == 11) begin
        bus.tx_data  = 8'h3C;
        bus.tx_start = 1'b1;
      end
      if (i == 12) bus.tx_start = 1'b0;
    end
    check("ign_start_bit", cap[0],  0);
    check("ign_data_bit2", cap[13], 1);
    check("ign_data_bit6", cap[29], 1);
    check("ign_frames",    rise_q.size(), 1);
    check("ign_busy_len",  busy_cnt, FLEN);
    check("ign_done_cnt",  done_cnt, 1);
    idle_cycles(3);

    // ---- back-to-back with tx_start held ----
    clear_stats();
    bus.tx_data  = 8'h55;
    bus.tx_start = 1'b1;
    for (int i = 0; i < 2 * FLEN + 6; i++) begin
      step_sample(i);
      if (i == 0)        bus.tx_data  = 8'h0F;
      if (i == FLEN + 1) bus.tx_start = 1'b0;
    end
    check("b2b_frames", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      check("b2b_spacing", rise_q[1] - rise_q[0], FLEN + 1);
    end
    check("b2b_1st_bit0",  cap[4],             1);   // 0x55 bit0
    check("b2b_1st_bit1",  cap[8],             0);   // 0x55 bit1
    check("b2b_2nd_start", cap[FLEN + 1],      0);
    check("b2b_2nd_bit0",  cap[FLEN + 1 + 4],  1);   // 0x0F bit0
    check("b2b_2nd_bit4",  cap[FLEN + 1 + 20], 0);   // 0x0F bit4
    check("b2b_done_cnt",  done_cnt, 2);
    idle_cycles(3);

    // ---- reset during data bit 3 of 0x00 ----
    clear_stats();
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step_sample(i);
      if (i == 0) bus.tx_start = 1'b0;
      if (i == 17) begin
        check("mrst_pre_tx", int'(bus.tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_async_tx",   int'(bus.tx),      1);
        check("mrst_async_busy", int'(bus.tx_busy), 0);
      end
      if (i == 19) rst_n = 1'b1;
    end
    for (int i = 20; i < FLEN + 8; i++) step_sample(i);
    check("mrst_done_cnt", done_cnt, 0);
    check("mrst_busy_cnt", busy_cnt, 18);

    // fresh frame after release
    clear_stats();
    bus.tx_data  = 8'h81;
    bus.tx_start = 1'b1;
    for (int i = 0; i < FLEN + 5; i++) begin
      step_sample(i);
      if (i == 0) bus.tx_start = 1'b0;
    end
    for (int i = 0; i < FLEN; i += CPB) check("x81_bit", cap[i + 1], lit_81[i / CPB]);
    check("x81_done_at", done_at, FLEN);
    idle_cycles(3);

`ifdef UART_TX_PARITY_EN
    // ---- parity bit ----
    clear_stats();
    bus.tx_data  = 8'h07;
    bus.tx_start = 1'b1;
    for (int i = 0; i < FLEN + 5; i++) begin
      step_sample(i);
      if (i == 0) bus.tx_start = 1'b0;
    end
    check("par07_bit",  cap[37], 1);
    check("par07_len",  busy_cnt, 44);
    idle_cycles(3);

    clear_stats();
    bus.tx_data  = 8'h03;
    bus.tx_start = 1'b1;
    for (int i = 0; i < FLEN + 5; i++) begin
      step_sample(i);
      if (i == 0) bus.tx_start = 1'b0;
    end
    check("par03_bit",  cap[37], 0);
    check("par03_stop", cap[41], 1);
    idle_cycles(3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
